// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator processor control path: opcodes,
// ALU selects, PC mux encodings, the control FSM state type and the bit
// positions of the branch/PC-write vectors that the PC write logic decodes.
package acc_pkg;

  localparam int OPC_W = 4;
  localparam int ALU_W = 3;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDA  = 4'h1;
  localparam logic [OPC_W-1:0] OP_STA  = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h4;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h5;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h6;
  localparam logic [OPC_W-1:0] OP_BEQ  = 4'h7;
  localparam logic [OPC_W-1:0] OP_BNE  = 4'h8;
  localparam logic [OPC_W-1:0] OP_BMI  = 4'h9;
  localparam logic [OPC_W-1:0] OP_BPL  = 4'hA;
  localparam logic [OPC_W-1:0] OP_JSR  = 4'hB;
  localparam logic [OPC_W-1:0] OP_RTS  = 4'hC;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  localparam logic [ALU_W-1:0] ALU_PASS_B = 3'b000;
  localparam logic [ALU_W-1:0] ALU_ADD    = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SUB    = 3'b010;
  localparam logic [ALU_W-1:0] ALU_AND    = 3'b011;
  localparam logic [ALU_W-1:0] ALU_OR     = 3'b100;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;  // PC + 4
  localparam logic [1:0] PCSRC_TARGET = 2'b01;  // operand target
  localparam logic [1:0] PCSRC_RETURN = 2'b10;  // return-address register

  // BranchLogicSignals bit positions: {BEQ, BMI, BNE, BPL, ZeroSig, NegSig, PCWrite}
  localparam int BLS_BEQ  = 6;
  localparam int BLS_BMI  = 5;
  localparam int BLS_BNE  = 4;
  localparam int BLS_BPL  = 3;
  localparam int BLS_ZERO = 2;
  localparam int BLS_NEG  = 1;
  localparam int BLS_PCW  = 0;

  // PCWriteSignals bit positions: {RTS, Cycle2, PCWrite}
  localparam int PCW_RTS    = 2;
  localparam int PCW_CYCLE2 = 1;
  localparam int PCW_WRITE  = 0;

  // The only two non-idle PC-write patterns; 3'b111 is never produced.
  localparam logic [2:0] PCW_SEQ_OR_JUMP = 3'b011;
  localparam logic [2:0] PCW_RETURN      = 3'b101;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEM_RD = 4'd2,
    ST_ACC_WB = 4'd3,
    ST_MEM_WR = 4'd4,
    ST_BRANCH = 4'd5,
    ST_JUMP   = 4'd6,
    ST_RETURN = 4'd7,
    ST_HALT   = 4'd8
  } state_e;

  // Per-state strobe set; held in a register so outputs are glitch-free.
  typedef struct packed {
    logic             mem_read;
    logic             mem_write;
    logic             fetch;
    logic             acc_write;
    logic             ra_write;
    logic [ALU_W-1:0] aluop;
    logic [1:0]       pcsource;
    logic             br_beq;
    logic             br_bmi;
    logic             br_bne;
    logic             br_bpl;
    logic             br_pcwrite;
    logic [2:0]       pcw;
    logic             halted;
  } ctrl_t;

  function automatic logic [ALU_W-1:0] alu_for(logic [OPC_W-1:0] op);
    logic [ALU_W-1:0] sel;
    sel = ALU_PASS_B;
    case (op)
      OP_ADD:  sel = ALU_ADD;
      OP_SUB:  sel = ALU_SUB;
      OP_AND:  sel = ALU_AND;
      OP_OR:   sel = ALU_OR;
      default: sel = ALU_PASS_B;
    endcase
    return sel;
  endfunction

  // Strobes for a state; the opcode only matters in ACC_WB and BRANCH,
  // where it is already stable because the IR was loaded in FETCH.
  function automatic ctrl_t ctrl_for(state_e s, logic [OPC_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_read = 1'b1;
        c.fetch    = 1'b1;
      end
      ST_DECODE: begin
        c.pcw      = PCW_SEQ_OR_JUMP;
        c.pcsource = PCSRC_SEQ;
      end
      ST_MEM_RD: c.mem_read = 1'b1;
      ST_ACC_WB: begin
        c.acc_write = 1'b1;
        c.aluop     = alu_for(op);
      end
      ST_MEM_WR: c.mem_write = 1'b1;
      ST_BRANCH: begin
        c.br_pcwrite = 1'b1;
        c.pcsource   = PCSRC_TARGET;
        case (op)
          OP_BEQ:  c.br_beq = 1'b1;
          OP_BMI:  c.br_bmi = 1'b1;
          OP_BNE:  c.br_bne = 1'b1;
          OP_BPL:  c.br_bpl = 1'b1;
          default: c.br_pcwrite = 1'b1;
        endcase
      end
      ST_JUMP: begin
        c.ra_write = 1'b1;
        c.pcw      = PCW_SEQ_OR_JUMP;
        c.pcsource = PCSRC_TARGET;
      end
      ST_RETURN: begin
        c.pcw      = PCW_RETURN;
        c.pcsource = PCSRC_RETURN;
      end
      ST_HALT: c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/acc_control_fsm.sv
// Multi-cycle control unit for the accumulator processor: steps each
// instruction through fetch/decode/execute with a memory ready handshake and
// drives the PC write interface plus datapath strobes.
// Optional retired-instruction counter: define ACC_CTRL_RETIRE_COUNT_EN.
//
// state  | meaning
// -------+---------------------------------------------------------------
// FETCH  | read instruction memory, load IR when MemReady
// DECODE | PC <= PC+4, branch on opcode
// MEM_RD | operand read for LDA/ALU ops, wait for MemReady
// ACC_WB | write ALU result into the accumulator
// MEM_WR | accumulator store for STA, wait for MemReady
// BRANCH | conditional branch; taken/not-taken resolved downstream
// JUMP   | JSR: save return address, PC <= target
// RETURN | RTS: PC <= return address
// HALT   | stopped until reset
//
// Strobes are registered from the state being entered, so they line up with
// the state register. "started" keeps outputs (including the flag
// pass-through) at zero through reset and the first clock after release,
// then FETCH begins with MemRead asserted before any handshake is sampled.
module acc_control_fsm
  import acc_pkg::*;
#(
  parameter int OPCODE_W = OPC_W,
  parameter int ALUOP_W  = ALU_W
`ifdef ACC_CTRL_RETIRE_COUNT_EN
  , parameter int RETIRE_CNT_W = 32
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                MemReady,
  input  logic                ZeroFlag,
  input  logic                NegFlag,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                AccWrite,
  output logic                RAWrite,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          PCSource,
  output logic [6:0]          BranchLogicSignals,
  output logic [2:0]          PCWriteSignals,
  output logic                Halted
`ifdef ACC_CTRL_RETIRE_COUNT_EN
  , output logic [RETIRE_CNT_W-1:0] RetireCount
`endif
);

  state_e state;
  state_e state_nxt;
  logic   started;
  ctrl_t  ctrl_q;

  // next state from the current state, handshake and opcode
  always_comb begin
    state_nxt = state;
    if (!started) begin
      state_nxt = ST_FETCH;
    end else begin
      case (state)
        ST_FETCH:  if (MemReady) state_nxt = ST_DECODE;
        ST_DECODE: begin
          case (Opcode)
            OP_NOP:                             state_nxt = ST_FETCH;
            OP_LDA, OP_ADD, OP_SUB, OP_AND,
            OP_OR:                              state_nxt = ST_MEM_RD;
            OP_STA:                             state_nxt = ST_MEM_WR;
            OP_BEQ, OP_BNE, OP_BMI, OP_BPL:     state_nxt = ST_BRANCH;
            OP_JSR:                             state_nxt = ST_JUMP;
            OP_RTS:                             state_nxt = ST_RETURN;
            OP_HALT:                            state_nxt = ST_HALT;
            default:                            state_nxt = ST_FETCH;
          endcase
        end
        ST_MEM_RD: if (MemReady) state_nxt = ST_ACC_WB;
        ST_ACC_WB: state_nxt = ST_FETCH;
        ST_MEM_WR: if (MemReady) state_nxt = ST_FETCH;
        ST_BRANCH: state_nxt = ST_FETCH;
        ST_JUMP:   state_nxt = ST_FETCH;
        ST_RETURN: state_nxt = ST_FETCH;
        ST_HALT:   state_nxt = ST_HALT;
        default:   state_nxt = ST_FETCH;
      endcase
    end
  end

  // state register plus registered strobes for the state being entered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_FETCH;
      started <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      started <= 1'b1;
      state   <= state_nxt;
      ctrl_q  <= ctrl_for(state_nxt, Opcode);
    end
  end

  // drive ports from the strobe register; flags pass straight through
  always_comb begin
    MemRead  = ctrl_q.mem_read;
    MemWrite = ctrl_q.mem_write;
    IRWrite  = ctrl_q.fetch & MemReady;
    AccWrite = ctrl_q.acc_write;
    RAWrite  = ctrl_q.ra_write;
    ALUOp    = ALUOP_W'(ctrl_q.aluop);
    PCSource = ctrl_q.pcsource;
    Halted   = ctrl_q.halted;

    BranchLogicSignals           = '0;
    BranchLogicSignals[BLS_BEQ]  = ctrl_q.br_beq;
    BranchLogicSignals[BLS_BMI]  = ctrl_q.br_bmi;
    BranchLogicSignals[BLS_BNE]  = ctrl_q.br_bne;
    BranchLogicSignals[BLS_BPL]  = ctrl_q.br_bpl;
    BranchLogicSignals[BLS_ZERO] = started & ZeroFlag;
    BranchLogicSignals[BLS_NEG]  = started & NegFlag;
    BranchLogicSignals[BLS_PCW]  = ctrl_q.br_pcwrite;

    PCWriteSignals             = '0;
    PCWriteSignals[PCW_RTS]    = ctrl_q.pcw[PCW_RTS];
    PCWriteSignals[PCW_CYCLE2] = ctrl_q.pcw[PCW_CYCLE2];
    PCWriteSignals[PCW_WRITE]  = ctrl_q.pcw[PCW_WRITE];
  end

`ifdef ACC_CTRL_RETIRE_COUNT_EN
  // An instruction retires when control returns to FETCH, or on entering HALT.
  logic retire_evt;
  assign retire_evt = started &&
                      (((state != ST_FETCH) && (state_nxt == ST_FETCH)) ||
                       ((state != ST_HALT)  && (state_nxt == ST_HALT)));

  // retired-instruction counter, wraps naturally
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      RetireCount <= '0;
    end else if (retire_evt) begin
      RetireCount <= RetireCount + RETIRE_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_acc_control_fsm.sv
// Testbench for acc_control_fsm. Builds the expected per-cycle output trace of
// each instruction from its opcode and memory wait counts, then plays it.
module tb_acc_control_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] Opcode = 4'h0;
  logic       MemReady = 1'b0;
  logic       ZeroFlag = 1'b0;
  logic       NegFlag = 1'b0;
  logic       MemRead, MemWrite, IRWrite, AccWrite, RAWrite, Halted;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic [6:0] BranchLogicSignals;
  logic [2:0] PCWriteSignals;
`ifdef ACC_CTRL_RETIRE_COUNT_EN
  logic [31:0] RetireCount;
`endif

  acc_control_fsm dut (
    .clock(clock), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .ZeroFlag(ZeroFlag), .NegFlag(NegFlag), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .AccWrite(AccWrite),
    .RAWrite(RAWrite), .ALUOp(ALUOp), .PCSource(PCSource),
    .BranchLogicSignals(BranchLogicSignals), .PCWriteSignals(PCWriteSignals),
    .Halted(Halted)
`ifdef ACC_CTRL_RETIRE_COUNT_EN
    , .RetireCount(RetireCount)
`endif
  );

  always #5 clock = ~clock;

  // {MemRead, MemWrite, IRWrite, AccWrite, RAWrite, ALUOp, PCSource, BLS, PCW, Halted}
  logic [20:0] obs;
  assign obs = {MemRead, MemWrite, IRWrite, AccWrite, RAWrite, ALUOp, PCSource,
                BranchLogicSignals, PCWriteSignals, Halted};

  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_RD   = 5'b10000;
  localparam logic [4:0] S_IR   = 5'b10100;
  localparam logic [4:0] S_WR   = 5'b01000;
  localparam logic [4:0] S_ACC  = 5'b00010;
  localparam logic [4:0] S_RA   = 5'b00001;

  typedef struct {
    logic        ready;
    logic [3:0]  op;
    logic [20:0] exp;
    bit          chk_ret;
    int          ret_val;
  } cyc_t;

  cyc_t q[$];
  int   retire_exp = 0;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [20:0] pk(logic [4:0] s, logic [2:0] alu, logic [1:0] pcs,
                                     logic [6:0] bls, logic [2:0] pcw, logic h);
    return {s, alu, pcs, bls, pcw, h};
  endfunction

  function automatic logic [2:0] alu_exp(logic [3:0] op);
    case (op)
      4'h3:    return 3'b001;
      4'h4:    return 3'b010;
      4'h5:    return 3'b011;
      4'h6:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic add(input logic r, input logic [3:0] o, input logic [20:0] e,
                     input bit c, input int v);
    cyc_t x;
    x.ready = r; x.op = o; x.exp = e; x.chk_ret = c; x.ret_val = v;
    q.push_back(x);
  endtask

  // Expected trace of one instruction (flag pass-through bits filled in at play time).
  task automatic build_instr(input logic [3:0] op, input int fw, input int mwt, input int nhalt);
    logic [6:0] b;
    q.delete();
    for (int i = 0; i < fw; i++)
      add(1'b0, 4'($urandom_range(0, 15)), pk(S_RD, 3'd0, 2'd0, 7'd0, 3'd0, 1'b0), i == 0, retire_exp);
    add(1'b1, 4'($urandom_range(0, 15)), pk(S_IR, 3'd0, 2'd0, 7'd0, 3'd0, 1'b0), fw == 0, retire_exp);
    add(1'($urandom_range(0, 1)), op, pk(S_NONE, 3'd0, 2'b00, 7'd0, 3'b011, 1'b0), 1'b0, 0);
    case (op)
      4'h1, 4'h3, 4'h4, 4'h5, 4'h6: begin
        for (int i = 0; i < mwt; i++) add(1'b0, op, pk(S_RD, 3'd0, 2'd0, 7'd0, 3'd0, 1'b0), 1'b0, 0);
        add(1'b1, op, pk(S_RD, 3'd0, 2'd0, 7'd0, 3'd0, 1'b0), 1'b0, 0);
        add(1'($urandom_range(0, 1)), op, pk(S_ACC, alu_exp(op), 2'd0, 7'd0, 3'd0, 1'b0), 1'b0, 0);
      end
      4'h2: begin
        for (int i = 0; i < mwt; i++) add(1'b0, op, pk(S_WR, 3'd0, 2'd0, 7'd0, 3'd0, 1'b0), 1'b0, 0);
        add(1'b1, op, pk(S_WR, 3'd0, 2'd0, 7'd0, 3'd0, 1'b0), 1'b0, 0);
      end
      4'h7, 4'h8, 4'h9, 4'hA: begin
        case (op)
          4'h7:    b = 7'b1000001;
          4'h8:    b = 7'b0010001;
          4'h9:    b = 7'b0100001;
          default: b = 7'b0001001;
        endcase
        add(1'($urandom_range(0, 1)), op, pk(S_NONE, 3'd0, 2'b01, b, 3'b000, 1'b0), 1'b0, 0);
      end
      4'hB: add(1'($urandom_range(0, 1)), op, pk(S_RA, 3'd0, 2'b01, 7'd0, 3'b011, 1'b0), 1'b0, 0);
      4'hC: add(1'($urandom_range(0, 1)), op, pk(S_NONE, 3'd0, 2'b10, 7'd0, 3'b101, 1'b0), 1'b0, 0);
      4'hF: for (int h = 0; h < nhalt; h++)
              add(1'($urandom_range(0, 1)), op, pk(S_NONE, 3'd0, 2'd0, 7'd0, 3'd0, 1'b1), h == 0, retire_exp + 1);
      default: ;
    endcase
    retire_exp++;
  endtask

  task automatic test_reset();
    logic [20:0] e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      MemReady = 1'b1; ZeroFlag = 1'($urandom_range(0, 1)); NegFlag = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (obs !== 21'd0) begin errors++; $display("FAIL reset_hold got=%b exp=0", obs); end
`ifdef ACC_CTRL_RETIRE_COUNT_EN
      checks++;
      if (RetireCount !== 32'd0) begin errors++; $display("FAIL reset_retire got=%0d exp=0", RetireCount); end
`endif
    end
    reset = 1'b1;
    retire_exp = 0;
    // LDA with long operand wait, abandoned by reset two cycles into MEM_RD
    build_instr(4'h1, 0, 5, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      MemReady = q[k].ready; Opcode = q[k].op;
      ZeroFlag = 1'($urandom_range(0, 1)); NegFlag = 1'($urandom_range(0, 1));
      #1;
      e = q[k].exp; e[6] = ZeroFlag; e[5] = NegFlag;
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_pre cyc=%0d got=%b exp=%b", k, obs, e); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      reset = 1'b0; MemReady = 1'b1;
      ZeroFlag = 1'($urandom_range(0, 1)); NegFlag = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (obs !== 21'd0) begin errors++; $display("FAIL reset_mid cyc=%0d got=%b exp=0", i, obs); end
    end
    reset = 1'b1;
    retire_exp = 0;
    build_instr(4'h0, 1, 0, 0);
    foreach (q[k]) begin
      @(negedge clock);
      MemReady = q[k].ready; Opcode = q[k].op;
      ZeroFlag = 1'($urandom_range(0, 1)); NegFlag = 1'($urandom_range(0, 1));
      #1;
      e = q[k].exp; e[6] = ZeroFlag; e[5] = NegFlag;
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_release cyc=%0d got=%b exp=%b", k, obs, e); end
`ifdef ACC_CTRL_RETIRE_COUNT_EN
      if (q[k].chk_ret) begin
        checks++;
        if (RetireCount !== 32'(q[k].ret_val)) begin
          errors++; $display("FAIL reset_release_retire got=%0d exp=%0d", RetireCount, q[k].ret_val);
        end
      end
`endif
    end
  endtask

  task automatic test_directed();
    logic [3:0]  ops   [15] = '{4'h0, 4'h3, 4'h7, 4'h8, 4'hB, 4'hC, 4'hE, 4'h2,
                                4'h1, 4'h4, 4'h5, 4'h6, 4'h9, 4'hA, 4'hD};
    int          waits [15] = '{0, 2, 0, 0, 0, 0, 0, 1, 0, 1, 3, 0, 0, 0, 0};
    logic [20:0] e;
    for (int t = 0; t < 15; t++) begin
      build_instr(ops[t], t % 2, waits[t], 0);
      foreach (q[k]) begin
        @(negedge clock);
        MemReady = q[k].ready; Opcode = q[k].op;
        ZeroFlag = 1'($urandom_range(0, 1)); NegFlag = 1'($urandom_range(0, 1));
        #1;
        e = q[k].exp; e[6] = ZeroFlag; e[5] = NegFlag;
        checks++;
        if (obs !== e) begin
          errors++; $display("FAIL directed op=%h cyc=%0d got=%b exp=%b", ops[t], k, obs, e);
        end
`ifdef ACC_CTRL_RETIRE_COUNT_EN
        if (q[k].chk_ret) begin
          checks++;
          if (RetireCount !== 32'(q[k].ret_val)) begin
            errors++; $display("FAIL directed_retire got=%0d exp=%0d", RetireCount, q[k].ret_val);
          end
        end
`endif
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op;
    logic [20:0] e;
    for (int t = 0; t < 60; t++) begin
      op = 4'($urandom_range(0, 14));
      build_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 0);
      foreach (q[k]) begin
        @(negedge clock);
        MemReady = q[k].ready; Opcode = q[k].op;
        ZeroFlag = 1'($urandom_range(0, 1)); NegFlag = 1'($urandom_range(0, 1));
        #1;
        e = q[k].exp; e[6] = ZeroFlag; e[5] = NegFlag;
        checks++;
        if (obs !== e) begin
          errors++; $display("FAIL b2b op=%h cyc=%0d got=%b exp=%b", op, k, obs, e);
        end
        checks++;
        if (PCWriteSignals === 3'b111) begin
          errors++; $display("FAIL b2b_pcw111 got=%b exp=not 111", PCWriteSignals);
        end
        checks++;
        if ((BranchLogicSignals & 7'b1111001) != 7'd0 && PCWriteSignals != 3'd0) begin
          errors++; $display("FAIL b2b_overlap bls=%b pcw=%b exp=exclusive", BranchLogicSignals, PCWriteSignals);
        end
`ifdef ACC_CTRL_RETIRE_COUNT_EN
        if (q[k].chk_ret) begin
          checks++;
          if (RetireCount !== 32'(q[k].ret_val)) begin
            errors++; $display("FAIL b2b_retire got=%0d exp=%0d", RetireCount, q[k].ret_val);
          end
        end
`endif
      end
    end
  endtask

  task automatic test_halt();
    logic [3:0]  ops [3] = '{4'hF, 4'h0, 4'hF};
    int          nh  [3] = '{20, 0, 3};
    logic [20:0] e;
    for (int t = 0; t < 3; t++) begin
      if (t == 1) begin
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 21'd0) begin errors++; $display("FAIL halt_reset got=%b exp=0", obs); end
        @(negedge clock);
        reset = 1'b1;
        retire_exp = 0;
      end
      build_instr(ops[t], 0, 0, nh[t]);
      foreach (q[k]) begin
        @(negedge clock);
        MemReady = q[k].ready; Opcode = q[k].op;
        ZeroFlag = 1'($urandom_range(0, 1)); NegFlag = 1'($urandom_range(0, 1));
        #1;
        e = q[k].exp; e[6] = ZeroFlag; e[5] = NegFlag;
        checks++;
        if (obs !== e) begin
          errors++; $display("FAIL halt step=%0d cyc=%0d got=%b exp=%b", t, k, obs, e);
        end
`ifdef ACC_CTRL_RETIRE_COUNT_EN
        if (q[k].chk_ret) begin
          checks++;
          if (RetireCount !== 32'(q[k].ret_val)) begin
            errors++; $display("FAIL halt_retire step=%0d got=%0d exp=%0d", t, RetireCount, q[k].ret_val);
          end
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
